// File: rtl/uart_rx_core_if.sv
// Receiver-side bundle between the UART register block and uart_rx_core.
// The register block drives enable/line and copies data and flags back.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_en;
  logic                 data_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 done;
  logic                 err;
  logic                 busy;

  modport master (
    output rx_en,
    output data_in,
    input  data_out,
    input  done,
    input  err,
    input  busy
  );

  modport slave (
    input  rx_en,
    input  data_in,
    output data_out,
    output done,
    output err,
    output busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop line sync, start-bit validation,
// three-tap majority sampling, level-held done/err flags.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input logic           clk,
  input logic           rst,
  uart_rx_core_if.slave rx
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } state_t;

  state_t state, state_n;

  logic                 sync1, sync2;
  logic                 rxs;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 tap0, tap0_n;
  logic                 tap1, tap1_n;
  logic [DATA_BITS-1:0] data_q, data_n;
  logic                 done_q, done_n;
  logic                 err_q, err_n;

  logic at_lo, at_mid, at_dec, at_wrap, maj;

  assign rxs     = sync2;
  assign at_lo   = (cnt == CW'(HALF - 1));
  assign at_mid  = (cnt == CW'(HALF));
  assign at_dec  = (cnt == CW'(HALF + 1));
  assign at_wrap = (cnt == CW'(CLKS_PER_BIT - 1));
  assign maj     = (tap0 & tap1) | (tap0 & rxs) | (tap1 & rxs);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx.data_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tap0    <= 1'b1;
      tap1    <= 1'b1;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tap0    <= tap0_n;
      tap1    <= tap1_n;
      data_q  <= data_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tap0_n    = tap0;
    tap1_n    = tap1;
    data_n    = data_q;
    done_n    = done_q;
    err_n     = err_q;

    if (state != IDLE) begin
      cnt_n = at_wrap ? '0 : cnt + CW'(1);
      if (at_lo)  tap0_n = rxs;
      if (at_mid) tap1_n = rxs;
    end

    unique case (state)
      IDLE: begin
        // The detecting edge is count 0 of the start bit.
        if (rx.rx_en && !rxs) begin
          state_n = START;
          cnt_n   = CW'(1);
        end
      end
      START: begin
        if (at_dec && maj) begin
          state_n = IDLE;
        end else if (at_dec) begin
          done_n    = 1'b0;
          err_n     = 1'b0;
          bit_idx_n = '0;
        end else if (at_wrap) begin
          state_n = DATA;
        end
      end
      DATA: begin
        if (at_dec)
          shreg_n = {maj, shreg[DATA_BITS-1:1]};
        if (at_wrap) begin
          if (bit_idx == BW'(DATA_BITS - 1))
            state_n = STOP;
          else
            bit_idx_n = bit_idx + BW'(1);
        end
      end
      STOP: begin
        if (at_dec && maj) begin
          data_n  = shreg;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (at_dec) begin
          err_n   = 1'b1;
          state_n = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (state != IDLE && !rx.rx_en) begin
      state_n = IDLE;
      data_n  = data_q;
      done_n  = done_q;
      err_n   = err_q;
    end

    if (state_n == IDLE || state_n == WAIT_HI)
      cnt_n = '0;
  end

  assign rx.data_out = data_q;
  assign rx.done     = done_q;
  assign rx.err      = err_q;
  assign rx.busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: vector table, corner sequences,
// and random frames against a frame-level reference model.
module tb_uart_rx_core;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  // Edge 1 samples the pin, rxs is low from edge 2, edge 3 is cnt 0.
  localparam int LAT  = 3 + 9 * CPB + HALF + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_core_if #(.DATA_BITS(8)) bus ();

  uart_rx_core #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx (bus)
  );

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         gbit;
    int         goff;
    int         hold;
    logic [7:0] e_data;
    logic       e_done;
    logic       e_err;
  } vec_t;

  vec_t tbl[5];

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_data;
  logic       exp_done;
  logic       exp_err;

  int   done_k;
  int   busy_fall_k;
  logic saw_busy;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.data_in = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int gbit, input int goff,
                            input int abit, input int aoff,
                            input int amode);
    logic [9:0] bits;
    logic       prev_done, prev_busy, aborted, trig;
    int         k;
    bits        = {stop, b, 1'b0};
    k           = 0;
    done_k      = -1;
    busy_fall_k = -1;
    saw_busy    = 1'b0;
    aborted     = 1'b0;
    prev_done   = bus.done;
    prev_busy   = bus.busy;
    for (int n = 0; n < 10; n++) begin
      for (int c = 0; c < CPB; c++) begin
        trig = 1'b0;
        if (aborted)
          bus.data_in = 1'b1;
        else if (n == gbit && c == goff)
          bus.data_in = ~bits[n];
        else
          bus.data_in = bits[n];
        if (!aborted && amode != 0 && n == abit && c == aoff) begin
          aborted = 1'b1;
          trig    = 1'b1;
          if (amode == 1) bus.rx_en = 1'b0;
          else rst = 1'b0;
        end
        tick();
        k++;
        if (bus.busy) saw_busy = 1'b1;
        if (bus.done && !prev_done && done_k < 0) done_k = k;
        if (!bus.busy && prev_busy && busy_fall_k < 0) busy_fall_k = k;
        prev_done = bus.done;
        prev_busy = bus.busy;
        if (trig && amode == 1) begin
          // A validated start has already cleared the flags.
          exp_done = 1'b0;
          exp_err  = 1'b0;
          chk("abort_busy", 32'(bus.busy), 0);
          chk("abort_done", 32'(bus.done), 32'(exp_done));
          chk("abort_data", 32'(bus.data_out), 32'(exp_data));
        end else if (trig) begin
          rst      = 1'b1;
          exp_data = 8'h00;
          exp_done = 1'b0;
          exp_err  = 1'b0;
          chk("rst_busy", 32'(bus.busy), 0);
          chk("rst_done", 32'(bus.done), 0);
          chk("rst_err", 32'(bus.err), 0);
          chk("rst_data", 32'(bus.data_out), 0);
        end
      end
    end
    if (amode == 1) begin
      idle(5);
      bus.rx_en = 1'b1;
    end
    if (!aborted) begin
      if (stop) begin
        exp_data = b;
        exp_done = 1'b1;
        exp_err  = 1'b0;
      end else begin
        exp_done = 1'b0;
        exp_err  = 1'b1;
      end
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_data"}, 32'(bus.data_out), 32'(exp_data));
    chk({tag, "_done"}, 32'(bus.done), 32'(exp_done));
    chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    int         gb, go, gap;

    tbl[0] = '{8'hA5, 1'b1, -1, 0, 0, 8'hA5, 1'b1, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, -1, 0, 40, 8'hA5, 1'b0, 1'b1};
    tbl[2] = '{8'h55, 1'b1, 3, HALF, 0, 8'h55, 1'b1, 1'b0};
    tbl[3] = '{8'h81, 1'b1, 0, HALF + 1, 0, 8'h81, 1'b1, 1'b0};
    tbl[4] = '{8'h3C, 1'b0, -1, 0, 0, 8'h81, 1'b0, 1'b1};

    bus.rx_en   = 1'b1;
    bus.data_in = 1'b1;
    rst         = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    exp_data = 8'h00;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    chk_outs("reset");
    chk("reset_busy", 32'(bus.busy), 0);
    rst = 1'b1;
    idle(10);

    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].b, tbl[i].stop, tbl[i].gbit, tbl[i].goff,
                 -1, 0, 0);
      if (tbl[i].e_done) begin
        chk($sformatf("vec%0d_done_lat", i), 32'(done_k), 32'(LAT));
        chk($sformatf("vec%0d_busy_fall", i), 32'(busy_fall_k),
            32'(LAT));
      end
      if (tbl[i].hold > 0) begin
        bus.data_in = 1'b0;
        for (int j = 0; j < tbl[i].hold; j++) tick();
        chk($sformatf("vec%0d_wait_hi", i), 32'(bus.busy), 1);
      end
      idle(30);
      chk($sformatf("vec%0d_data", i), 32'(bus.data_out),
          32'(tbl[i].e_data));
      chk($sformatf("vec%0d_done", i), 32'(bus.done),
          32'(tbl[i].e_done));
      chk($sformatf("vec%0d_err", i), 32'(bus.err), 32'(tbl[i].e_err));
      chk($sformatf("vec%0d_idle", i), 32'(bus.busy), 0);
    end

    // Short low glitch on an idle line is a false start.
    idle(4);
    send_frame(8'hA5, 1'b1, -1, 0, -1, 0, 0);
    idle(20);
    bus.data_in = 1'b0;
    saw_busy    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.busy) saw_busy = 1'b1;
    end
    bus.data_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.busy) saw_busy = 1'b1;
    end
    chk("glitch_busy_pulse", 32'(saw_busy), 1);
    chk("glitch_idle", 32'(bus.busy), 0);
    chk_outs("glitch");

    send_frame(8'h96, 1'b1, -1, 0, 4, 5, 1);
    idle(10);
    chk_outs("en_abort");

    send_frame(8'h69, 1'b1, -1, 0, 6, 3, 2);
    idle(10);
    chk_outs("rst_abort");

    send_frame(8'h00, 1'b1, -1, 0, -1, 0, 0);
    chk("b2b0_done_lat", 32'(done_k), 32'(LAT));
    chk_outs("b2b0");
    send_frame(8'hFF, 1'b1, -1, 0, -1, 0, 0);
    chk("b2b1_done_lat", 32'(done_k), 32'(LAT));
    chk_outs("b2b1");
    idle(10);

    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(3) != 0);
      if ($urandom_range(1) != 0) begin
        gb = int'($urandom_range(8, 1));
        go = int'($urandom_range(CPB - 1));
      end else begin
        gb = -1;
        go = 0;
      end
      send_frame(rb, rs, gb, go, -1, 0, 0);
      if (rs)
        chk($sformatf("rnd%0d_done_lat", i), 32'(done_k), 32'(LAT));
      chk_outs($sformatf("rnd%0d", i));
      gap = int'($urandom_range(6)) + (rs ? 0 : 2);
      idle(gap);
    end

    idle(30);
    chk_outs("final");
    chk("final_idle", 32'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
